seq_prod_deser: RTL and testbench
=================================

// Module: seq_prod_deser
// PURPOSE
//  Receive side of the bit-serial multiplier digit stream. Collects the P-bit product digits,
//  which arrive LSB-first one per strobe, into a full parallel product word. Sign-extends the
//  word to 2*MAX_WIDTH and presents it on a valid/ready output port. Sits between the serial
//  multiplier datapath and the parallel result consumer; the multiplier controller drives start/digit_valid.
// PARAMETERS
//  P          2   digit width in bits (bits produced per cycle by the multiplier)
//  MAX_WIDTH  16  max operand width; product word is 2*MAX_WIDTH bits
// PORTS
//  clk          in   1                          clock
//  rst_n        in   1                          asynchronous, active-low reset
//  start        in   1                          begin new product; samples bit_size and signed_mode
//  bit_size     in   $clog2(MAX_WIDTH/P)+2      operand width in digits (operand bits = bit_size*P)
//  signed_mode  in   1                          1: sign-extend product, 0: zero-extend
//  digit_in     in   P                          product digit, LSB-first
//  digit_valid  in   1                          digit_in valid this cycle
//  prod         out  2*MAX_WIDTH                assembled, extended product
//  prod_valid   out  1                          prod valid; held until prod_ready
//  prod_ready   in   1                          consumer accepts prod
//  start_ready  out  1                          start will be accepted this cycle (combinational)
//  err          out  1                          1-cycle pulse: protocol violation (see below)
// BEHAVIOUR
//  Reset: state=IDLE; prod=0, prod_valid=0, err=0, digit counter=0, latched size/sign=0.
//   Reset is fully asynchronous and aborts any collection in progress.
//  Legal bit_size: 1..MAX_WIDTH/P. Digits per product N=2*bit_size. Product bits W=N*P.
//  FSM:
//   IDLE: start & legal size -> COLLECT; clear cnt and accumulator; latch bit_size, signed_mode.
//   COLLECT: each digit_valid writes digit_in to acc[cnt*P +: P] and increments cnt.
//    On the digit with cnt==N-1 -> HOLD.
//    The registered prod = acc[W-1:0] extended to 2*MAX_WIDTH. Upper bits = acc[W-1] if
//    signed_mode, else 0.
//   HOLD: prod_valid=1. prod stays stable until prod_ready.
//    prod_ready & !start -> IDLE, prod_valid=0 next cycle.
//    prod_ready & start (legal) -> COLLECT directly, with no bubble.
//  Latency: prod_valid rises the cycle after the last digit is accepted.
//  start_ready = (state==IDLE) | (state==COLLECT) | (state==HOLD & prod_ready).
//  Start in COLLECT: abort the current product and restart. Any digit in the same cycle is
//   discarded. err pulses (aborted product).
//  Start in HOLD without prod_ready: ignored; err pulses; prod is unchanged.
//  Illegal bit_size (0 or >MAX_WIDTH/P) on start: start is ignored, state is unchanged, err pulses.
//  digit_valid outside COLLECT (IDLE, HOLD, or the start cycle in IDLE): digit is dropped; err pulses.
//  prod is updated only on the COLLECT->HOLD transition. It is never cleared by prod_ready.
//  Counter width $clog2(2*MAX_WIDTH/P)+1. No wrap: cnt is cleared on every start.
// TESTING
//  1 P=2, bit_size=1, unsigned, digits 01,10 -> prod=32'h0000_0009, prod_valid 1 cycle after 2nd digit.
//  2 bit_size=2, signed, digits 00,11,11,11 (8'hFC) -> prod=32'hFFFF_FFFC; same with signed_mode=0
//    -> 32'h0000_00FC.
//  3 bit_size=8, 16 digits of 2'b11, unsigned -> prod=32'hFFFF_FFFF, start_ready stays 1 throughout.
//  4 prod_ready=0 for 5 cycles in HOLD, inject digit_valid and start -> err pulses on each;
//    prod/prod_valid unchanged.
//  5 start after 3 of 4 digits, then 4 new digits 01,00,00,00 -> err once; prod=32'h1.
//    HOLD with prod_ready&start -> next product with no idle cycle.
//  6 rst_n low mid-COLLECT (asynchronous, between edges) -> prod=0, prod_valid=0 immediately;
//    start with bit_size=0 -> err, stays IDLE.

Source files
------------

// File: rtl/seq_prod_deser.sv
// Receive side of the bit-serial multiplier: gathers P-bit product digits LSB-first,
// then presents the sign/zero-extended product on a valid/ready port.
module seq_prod_deser #(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16,
    localparam int PW   = 2 * MAX_WIDTH,
    localparam int MAXD = MAX_WIDTH / P,
    localparam int SW   = $clog2(MAXD) + 2,
    localparam int CW   = $clog2(2 * MAX_WIDTH / P) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [SW-1:0] bit_size,
    input  logic          signed_mode,
    input  logic [P-1:0]  digit_in,
    input  logic          digit_valid,
    output logic [PW-1:0] prod,
    output logic          prod_valid,
    input  logic          prod_ready,
    output logic          start_ready,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] acc_q;
    logic [SW-1:0] size_q;
    logic          sign_q;
    logic [PW-1:0] prod_q;
    logic          prod_valid_q;
    logic          err_q;

    logic          size_legal;
    logic [CW-1:0] last_idx;
    logic [PW-1:0] acc_d;
    logic [PW-1:0] prod_d;
    logic          msb;
    int            w;

    assign size_legal  = (bit_size != '0) && (bit_size <= SW'(MAXD));
    assign last_idx    = CW'(2 * int'(size_q) - 1);
    assign start_ready = (state_q == IDLE) || (state_q == COLLECT) ||
                         ((state_q == HOLD) && prod_ready);

    // Accumulator with the incoming digit merged in, and the extended word it would produce.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        acc_d  = acc_q;
        prod_d = '0;
        msb    = 1'b0;
        w      = 2 * P * int'(size_q);
        // NOTE: constant-bound loops compare against the counter instead of a variable part-select.
        for (int k = 0; k < 2 * MAXD; k++) begin
            if (cnt_q == CW'(k)) acc_d[k*P +: P] = digit_in;
        end
        for (int i = 0; i < PW; i++) begin
            if (i == w - 1) msb = acc_d[i];
        end
        for (int i = 0; i < PW; i++) begin
            prod_d[i] = (i < w) ? acc_d[i] : (sign_q & msb);
        end
    end

    // NOTE: all state is assigned non-blocking; reset is asynchronous and aborts any collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (digit_valid) err_q <= 1'b1;
                    if (start) begin
                        if (size_legal) begin
                            state_q <= COLLECT;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            size_q  <= bit_size;
                            sign_q  <= signed_mode;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (start && size_legal) begin
                        // Abort and restart; a digit in this cycle belongs to the dead product.
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        size_q <= bit_size;
                        sign_q <= signed_mode;
                        err_q  <= 1'b1;
                    end else begin
                        if (start) err_q <= 1'b1;
                        if (digit_valid) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == last_idx) begin
                                state_q      <= HOLD;
                                prod_q       <= prod_d;
                                prod_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (digit_valid) err_q <= 1'b1;
                    if (prod_ready) begin
                        prod_valid_q <= 1'b0;
                        if (start && size_legal) begin
                            state_q <= COLLECT;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            size_q  <= bit_size;
                            sign_q  <= signed_mode;
                        end else begin
                            state_q <= IDLE;
                            if (start) err_q <= 1'b1;
                        end
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod       = prod_q;
    assign prod_valid = prod_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seq_prod_deser.sv
// Directed bench for seq_prod_deser: expected products go into a queue, a negedge
// monitor pops and compares on every accepted handshake.
module tb_seq_prod_deser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  bit_size;
    logic        signed_mode;
    logic [1:0]  digit_in;
    logic        digit_valid;
    logic [31:0] prod;
    logic        prod_valid;
    logic        prod_ready;
    logic        start_ready;
    logic        err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    seq_prod_deser #(.P(2), .MAX_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bit_size    (bit_size),
        .signed_mode (signed_mode),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .prod        (prod),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .start_ready (start_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] sz, input logic sgn);
        start       = 1'b1;
        bit_size    = sz;
        signed_mode = sgn;
        tick();
        start = 1'b0;
    endtask

    task automatic send_digit(input logic [1:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    // Monitor: compare every accepted product against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && prod_valid && prod_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_prod", prod, 32'hxxxx_xxxx);
                end else begin
                    check("prod", prod, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sr_ok;
        rst_n       = 1'b0;
        start       = 1'b0;
        bit_size    = '0;
        signed_mode = 1'b0;
        digit_in    = '0;
        digit_valid = 1'b0;
        prod_ready  = 1'b1;
        #23;
        check("rst_prod",        prod,        32'h0);
        check("rst_prod_valid",  32'(prod_valid),  32'h0);
        check("rst_err",         32'(err),         32'h0);
        check("rst_start_ready", 32'(start_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // 1: bit_size=1 unsigned, digits 01,10 -> 9, valid one cycle after last digit
        exp_q.push_back(32'h0000_0009);
        do_start(5'd1, 1'b0);
        send_digit(2'b01);
        check("t1_not_valid_early", 32'(prod_valid), 32'h0);
        send_digit(2'b10);
        check("t1_valid_latency", 32'(prod_valid), 32'h1);
        tick();
        check("t1_valid_drop", 32'(prod_valid), 32'h0);

        // 2: signed and unsigned extension of 8'hFC
        exp_q.push_back(32'hFFFF_FFFC);
        do_start(5'd2, 1'b1);
        send_digit(2'b00); send_digit(2'b11); send_digit(2'b11); send_digit(2'b11);
        tick();
        exp_q.push_back(32'h0000_00FC);
        do_start(5'd2, 1'b0);
        send_digit(2'b00); send_digit(2'b11); send_digit(2'b11); send_digit(2'b11);
        tick();

        // 3: max size, all ones, start_ready held high throughout
        exp_q.push_back(32'hFFFF_FFFF);
        sr_ok = 1'b1;
        do_start(5'd8, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (!start_ready) sr_ok = 1'b0;
            send_digit(2'b11);
        end
        if (!start_ready) sr_ok = 1'b0;
        check("t3_start_ready", 32'(sr_ok), 32'h1);
        tick();

        // 4: HOLD with prod_ready low; digit and start both flag err, prod stays put
        exp_q.push_back(32'h0000_0003);
        do_start(5'd1, 1'b0);
        send_digit(2'b11);
        prod_ready = 1'b0;
        send_digit(2'b00);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) digit_valid = 1'b1;
            if (i == 2) begin
                start    = 1'b1;
                bit_size = 5'd1;
                check("t4_start_ready_low", 32'(start_ready), 32'h0);
            end
            tick();
            digit_valid = 1'b0;
            start       = 1'b0;
            check($sformatf("t4_err_%0d", i), 32'(err), (i == 0 || i == 2) ? 32'h1 : 32'h0);
            check($sformatf("t4_valid_%0d", i), 32'(prod_valid), 32'h1);
            check($sformatf("t4_prod_%0d", i), prod, 32'h0000_0003);
        end
        prod_ready = 1'b1;
        tick();

        // 5: abort after 3 of 4 digits, then back-to-back start from HOLD
        exp_q.push_back(32'h0000_0001);
        do_start(5'd2, 1'b0);
        send_digit(2'b11); send_digit(2'b11); send_digit(2'b11);
        do_start(5'd2, 1'b0);
        check("t5_abort_err", 32'(err), 32'h1);
        send_digit(2'b01);
        check("t5_err_once", 32'(err), 32'h0);
        send_digit(2'b00); send_digit(2'b00); send_digit(2'b00);
        check("t5_hold", 32'(prod_valid), 32'h1);
        exp_q.push_back(32'h0000_0006);
        do_start(5'd1, 1'b0);
        check("t5_no_bubble_valid", 32'(prod_valid), 32'h0);
        check("t5_no_bubble_err", 32'(err), 32'h0);
        send_digit(2'b10);
        send_digit(2'b01);
        check("t5_second_valid", 32'(prod_valid), 32'h1);
        tick();

        // 6: asynchronous reset mid-collection, then illegal sizes are rejected
        do_start(5'd8, 1'b1);
        send_digit(2'b01); send_digit(2'b10); send_digit(2'b11);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_prod", prod, 32'h0);
        check("t6_async_valid", 32'(prod_valid), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        do_start(5'd0, 1'b0);
        check("t6_size0_err", 32'(err), 32'h1);
        send_digit(2'b11);
        check("t6_idle_digit_err", 32'(err), 32'h1);
        do_start(5'd9, 1'b0);
        check("t6_size9_err", 32'(err), 32'h1);
        check("t6_still_idle", 32'(prod_valid), 32'h0);
        exp_q.push_back(32'h0000_0004);
        do_start(5'd1, 1'b0);
        check("t6_legal_err", 32'(err), 32'h0);
        send_digit(2'b00);
        send_digit(2'b01);
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
